// File: rtl/word_compare_seq.sv
// word_compare_seq: chunk-serial magnitude comparator with a four-phase req
// handshake. Operands are captured on the req rising into IDLE, compared
// CHUNK bits per cycle from the MSB end, and the first mismatching chunk ends
// the compare early. The result is held in DONE until req drops.
// WIDTH must be an integer multiple of CHUNK.
module word_compare_seq #(
    parameter int WIDTH  = 32,
    parameter int CHUNK  = 8,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic [WIDTH-1:0]              x,
    input  logic [WIDTH-1:0]              y,
    output logic                          busy,
    output logic                          equal,
    output logic                          not_equal,
    output logic                          less,
    output logic                          greater,
    output logic [$clog2(WIDTH/CHUNK):0]  cycles
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK) + 1;

    localparam logic [CW-1:0] IDX_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] IDX_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] IDX_LAST = CW'(NCHUNK - 1);
    localparam logic [CW-1:0] CYC_FULL = CW'(NCHUNK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;

    // Captured operands; shifted left one chunk per matching step so the
    // chunk under test always sits in the top CHUNK bits.
    logic [WIDTH-1:0]  xa_r;
    logic [WIDTH-1:0]  ya_r;
    logic [WIDTH-1:0]  xa_next_s;
    logic [WIDTH-1:0]  ya_next_s;

    logic [CW-1:0]     idx_r;
    logic [CW-1:0]     idx_next_s;

    logic              busy_r;
    logic              equal_r;
    logic              not_equal_r;
    logic              less_r;
    logic              greater_r;
    logic [CW-1:0]     cycles_r;

    logic              busy_next_s;
    logic              equal_next_s;
    logic              not_equal_next_s;
    logic              less_next_s;
    logic              greater_next_s;
    logic [CW-1:0]     cycles_next_s;

    logic [CHUNK-1:0]  chunk_x_s;
    logic [CHUNK-1:0]  chunk_y_s;
    logic              chunk_neq_s;
    logic              chunk_lt_s;

    assign chunk_x_s = xa_r[WIDTH-1 -: CHUNK];
    assign chunk_y_s = ya_r[WIDTH-1 -: CHUNK];

    // Chunk compare; only the most significant chunk carries the sign.
    always_comb begin
        chunk_neq_s = (chunk_x_s != chunk_y_s);
        if ((SIGNED != 32'sd0) && (idx_r == IDX_ZERO)) begin
            chunk_lt_s = ($signed(chunk_x_s) < $signed(chunk_y_s));
        end else begin
            chunk_lt_s = (chunk_x_s < chunk_y_s);
        end
    end

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        next_state_s     = state_r;
        xa_next_s        = xa_r;
        ya_next_s        = ya_r;
        idx_next_s       = idx_r;
        busy_next_s      = busy_r;
        equal_next_s     = equal_r;
        not_equal_next_s = not_equal_r;
        less_next_s      = less_r;
        greater_next_s   = greater_r;
        cycles_next_s    = cycles_r;

        case (state_r)
            ST_IDLE: begin
                busy_next_s      = 1'b0;
                equal_next_s     = 1'b0;
                not_equal_next_s = 1'b0;
                less_next_s      = 1'b0;
                greater_next_s   = 1'b0;
                cycles_next_s    = IDX_ZERO;
                idx_next_s       = IDX_ZERO;
                if (req) begin
                    xa_next_s    = x;
                    ya_next_s    = y;
                    busy_next_s  = 1'b1;
                    next_state_s = ST_CMP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end

            ST_CMP: begin
                if (!req) begin
                    // Abort: drop back without publishing any result.
                    busy_next_s      = 1'b0;
                    equal_next_s     = 1'b0;
                    not_equal_next_s = 1'b0;
                    less_next_s      = 1'b0;
                    greater_next_s   = 1'b0;
                    cycles_next_s    = IDX_ZERO;
                    idx_next_s       = IDX_ZERO;
                    next_state_s     = ST_IDLE;
                end else if (chunk_neq_s) begin
                    busy_next_s      = 1'b0;
                    not_equal_next_s = 1'b1;
                    less_next_s      = chunk_lt_s;
                    greater_next_s   = !chunk_lt_s;
                    cycles_next_s    = idx_r + IDX_ONE;
                    next_state_s     = ST_DONE;
                end else if (idx_r == IDX_LAST) begin
                    busy_next_s      = 1'b0;
                    equal_next_s     = 1'b1;
                    cycles_next_s    = CYC_FULL;
                    next_state_s     = ST_DONE;
                end else begin
                    idx_next_s       = idx_r + IDX_ONE;
                    xa_next_s        = xa_r << CHUNK;
                    ya_next_s        = ya_r << CHUNK;
                    next_state_s     = ST_CMP;
                end
            end

            ST_DONE: begin
                busy_next_s = 1'b0;
                if (!req) begin
                    equal_next_s     = 1'b0;
                    not_equal_next_s = 1'b0;
                    less_next_s      = 1'b0;
                    greater_next_s   = 1'b0;
                    cycles_next_s    = IDX_ZERO;
                    idx_next_s       = IDX_ZERO;
                    next_state_s     = ST_IDLE;
                end else begin
                    next_state_s     = ST_DONE;
                end
            end

            default: begin
                busy_next_s      = 1'b0;
                equal_next_s     = 1'b0;
                not_equal_next_s = 1'b0;
                less_next_s      = 1'b0;
                greater_next_s   = 1'b0;
                cycles_next_s    = IDX_ZERO;
                idx_next_s       = IDX_ZERO;
                next_state_s     = ST_IDLE;
            end
        endcase
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            xa_r        <= {WIDTH{1'b0}};
            ya_r        <= {WIDTH{1'b0}};
            idx_r       <= IDX_ZERO;
            busy_r      <= 1'b0;
            equal_r     <= 1'b0;
            not_equal_r <= 1'b0;
            less_r      <= 1'b0;
            greater_r   <= 1'b0;
            cycles_r    <= IDX_ZERO;
        end else begin
            state_r     <= next_state_s;
            xa_r        <= xa_next_s;
            ya_r        <= ya_next_s;
            idx_r       <= idx_next_s;
            busy_r      <= busy_next_s;
            equal_r     <= equal_next_s;
            not_equal_r <= not_equal_next_s;
            less_r      <= less_next_s;
            greater_r   <= greater_next_s;
            cycles_r    <= cycles_next_s;
        end
    end

    assign busy      = busy_r;
    assign equal     = equal_r;
    assign not_equal = not_equal_r;
    assign less      = less_r;
    assign greater   = greater_r;
    assign cycles    = cycles_r;

endmodule

// File: tb/tb_word_compare_seq.sv
// Testbench for word_compare_seq: three instances (32/8 unsigned, 32/8 signed,
// 8/8 signed single-chunk) share one req/x/y stream; every cycle each output
// bundle is compared with a whole-word arithmetic reference model.
module tb_word_compare_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  x8;
    logic [7:0]  y8;

    logic busy_u, equal_u, not_equal_u, less_u, greater_u;
    logic [2:0] cycles_u;
    logic busy_s, equal_s, not_equal_s, less_s, greater_s;
    logic [2:0] cycles_s;
    logic busy_1, equal_1, not_equal_1, less_1, greater_1;
    logic [0:0] cycles_1;

    int n_total = 0;
    int n_pass  = 0;

    assign x8 = x[31:24];
    assign y8 = y[31:24];

    always #5 clk = ~clk;

    word_compare_seq #(.WIDTH(32), .CHUNK(8), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .req(req), .x(x), .y(y),
        .busy(busy_u), .equal(equal_u), .not_equal(not_equal_u),
        .less(less_u), .greater(greater_u), .cycles(cycles_u)
    );

    word_compare_seq #(.WIDTH(32), .CHUNK(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .req(req), .x(x), .y(y),
        .busy(busy_s), .equal(equal_s), .not_equal(not_equal_s),
        .less(less_s), .greater(greater_s), .cycles(cycles_s)
    );

    word_compare_seq #(.WIDTH(8), .CHUNK(8), .SIGNED(1)) u_dut_1 (
        .clk(clk), .rst(rst), .req(req), .x(x8), .y(y8),
        .busy(busy_1), .equal(equal_1), .not_equal(not_equal_1),
        .less(less_1), .greater(greater_1), .cycles(cycles_1)
    );

    function automatic logic [15:0] pack(input logic b, input logic e, input logic n,
                                         input logic l, input logic g, input logic [3:0] c);
        return {7'd0, b, e, n, l, g, c};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h (busy,eq,ne,lt,gt,cyc) expected %h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Whole-word reference: order from full integer compare, cycles from the
    // position of the first differing chunk counted from the MSB end.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input int w,
                         input int ch, input int sg, output logic eq, output logic lt,
                         output logic gt, output int cyc);
        longint av, bv, sa, sb, mask;
        bit found;
        av = longint'(a >> (32 - w));
        bv = longint'(b >> (32 - w));
        sa = av;
        sb = bv;
        if (sg != 0) begin
            if (av >= (64'sd1 <<< (w - 1))) sa = av - (64'sd1 <<< w);
            if (bv >= (64'sd1 <<< (w - 1))) sb = bv - (64'sd1 <<< w);
        end
        eq   = (av == bv);
        lt   = !eq && (sa < sb);
        gt   = !eq && (sa > sb);
        cyc  = w / ch;
        mask = (64'sd1 <<< ch) - 64'sd1;
        found = 1'b0;
        for (int k = 0; k < w / ch; k++) begin
            if (!found && (((av >> (w - (k + 1) * ch)) & mask) != ((bv >> (w - (k + 1) * ch)) & mask))) begin
                cyc   = k + 1;
                found = 1'b1;
            end
        end
    endtask

    function automatic logic [15:0] expect_at(input int j, input logic eq, input logic lt,
                                              input logic gt, input int cyc);
        if (j < cyc) return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        return pack(1'b0, eq, !eq, lt, gt, 4'(cyc));
    endfunction

    // j = number of edges since the capture edge N (0 = just captured).
    task automatic expect_all(input int j, input logic [31:0] a, input logic [31:0] b);
        logic eq, lt, gt;
        int cyc;
        model(a, b, 32, 8, 0, eq, lt, gt, cyc);
        check("u32", pack(busy_u, equal_u, not_equal_u, less_u, greater_u, 4'(cycles_u)),
              expect_at(j, eq, lt, gt, cyc));
        model(a, b, 32, 8, 1, eq, lt, gt, cyc);
        check("s32", pack(busy_s, equal_s, not_equal_s, less_s, greater_s, 4'(cycles_s)),
              expect_at(j, eq, lt, gt, cyc));
        model(a, b, 8, 8, 1, eq, lt, gt, cyc);
        check("s8", pack(busy_1, equal_1, not_equal_1, less_1, greater_1, 4'(cycles_1)),
              expect_at(j, eq, lt, gt, cyc));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_u32"}, pack(busy_u, equal_u, not_equal_u, less_u, greater_u, 4'(cycles_u)), 16'd0);
        check({tag, "_s32"}, pack(busy_s, equal_s, not_equal_s, less_s, greater_s, 4'(cycles_s)), 16'd0);
        check({tag, "_s8"},  pack(busy_1, equal_1, not_equal_1, less_1, greater_1, 4'(cycles_1)), 16'd0);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        x   = a;
        y   = b;
        req = 1'b1;
    endtask

    // Follow n cycles after capture, scrambling x/y so late changes must be ignored.
    task automatic track(input logic [31:0] a, input logic [31:0] b, input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            expect_all(j, a, b);
            x = $urandom;
            y = $urandom;
        end
    endtask

    task automatic release_chk();
        req = 1'b0;
        @(negedge clk);
        check_idle("release");
    endtask

    logic [31:0] dir_a [7] = '{32'hDEADBEEF, 32'h12FFFFFF, 32'hAABBCC05, 32'hAABBCC04,
                               32'hFF000000, 32'h00000000, 32'h80000000};
    logic [31:0] dir_b [7] = '{32'hDEADBEEF, 32'h13000000, 32'hAABBCC04, 32'hAABBCC05,
                               32'h01000000, 32'hFFFFFFFF, 32'h7FFFFFFF};

    initial begin
        logic [31:0] ra, rb;
        int sel;

        rst = 1'b1;
        req = 1'b0;
        x   = 32'd0;
        y   = 32'd0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");

        // Directed operand pairs, result held with req high for several cycles.
        for (int i = 0; i < 7; i++) begin
            start(dir_a[i], dir_b[i]);
            track(dir_a[i], dir_b[i], 7);
            release_chk();
        end

        // Abort after two CMP cycles.
        start(32'h5A5A5A5A, 32'h5A5A5A5A);
        track(32'h5A5A5A5A, 32'h5A5A5A5A, 2);
        req = 1'b0;
        @(negedge clk);
        check_idle("abort");
        @(negedge clk);
        check_idle("abort_hold");

        // Reset mid-CMP with req held high, then recapture after rst falls.
        start(32'h01020304, 32'h01020304);
        track(32'h01020304, 32'h01020304, 2);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_cmp");
        x   = 32'hC0000001;
        y   = 32'hC0000002;
        rst = 1'b0;
        track(32'hC0000001, 32'hC0000002, 5);

        // Reset in DONE with req still high, then recapture.
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_done");
        x   = 32'h7F00FF00;
        y   = 32'h8000FF00;
        rst = 1'b0;
        track(32'h7F00FF00, 32'h8000FF00, 5);
        release_chk();

        // Random pairs biased toward long shared prefixes.
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = ra;
            sel = $urandom_range(0, 4);
            if (sel < 4) rb[8 * (3 - sel) +: 8] = rb[8 * (3 - sel) +: 8] ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) rb = $urandom;
            start(ra, rb);
            track(ra, rb, 5);
            release_chk();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/word_compare_seq.md
Name: word_compare_seq

Overview:
Parametrised, clocked successor to the single-bit equal/not-equal flow-control cell. It compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, and stops early on the first mismatching chunk. It reports equal, not-equal and magnitude order (less/greater), plus the number of chunk compares used. It uses a four-phase req handshake and sits in the flow-control path, where its outputs steer branch/select logic.

Parameters:
WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK.
CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK, and NCHUNK >= 1.
SIGNED, 0, 1 = two's-complement order (MSB chunk compared signed, the rest unsigned); 0 = unsigned.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
req  input  1  four-phase request; high starts a compare, low releases the result.
x  input  WIDTH  operand A; sampled only at capture.
y  input  WIDTH  operand B; sampled only at capture.
busy  output  1  high while a compare is in progress (state CMP).
equal  output  1  result: x == y.
not_equal  output  1  result: x != y.
less  output  1  result: x < y (signedness per SIGNED).
greater  output  1  result: x > y.
cycles  output  $clog2(NCHUNK)+1  number of chunks compared (1..NCHUNK); valid with the result.

Behaviour:
- Reset: synchronous, active-high, and overrides req. It forces state IDLE and clears busy, equal, not_equal, less, greater, cycles and the chunk index to 0.
- States: IDLE, CMP, DONE.
- IDLE:
  - All outputs are 0.
  - If req=1 at edge N: capture x,y into internal registers, set index k=0, go to CMP. busy=1 after edge N.
- CMP, each edge:
  - If req=0: abort. Go to IDLE, busy=0, no result flag asserted, cycles=0.
  - Otherwise compare chunk k, i.e. bits [WIDTH-1-k*CHUNK -: CHUNK] of the captured operands:
    - Mismatch: not_equal=1, and exactly one of less/greater per the chunk compare. Signed compare applies only when SIGNED=1 and k=0. Set cycles=k+1, go to DONE.
    - Match and k==NCHUNK-1: equal=1, cycles=NCHUNK, go to DONE.
    - Match otherwise: k=k+1.
- Latency:
  - Mismatch in chunk k: result visible after edge N+1+k.
  - Full equality: result visible after edge N+NCHUNK.
  - busy falls on the same edge the result rises.
- DONE:
  - busy=0; result flags and cycles are held stable while req=1.
  - No re-trigger while req stays high.
  - On the first edge with req=0: clear all result outputs and go to IDLE.
  - A new compare needs req low for at least one edge, then high.
- Invariants:
  - At most one of equal/not_equal is high.
  - less/greater are high only together with not_equal, and are mutually exclusive.
  - All result flags are 0 outside DONE.
- Changes on x,y after capture are ignored.
- NCHUNK=1: single-cycle compare; the result appears after edge N+1.
- The index counter never exceeds NCHUNK-1; there is no wrap.
- All outputs are registered; no combinational path from req/x/y to any output.

Test Plan:
- WIDTH=32, CHUNK=8, SIGNED=0; x=y=0xDEADBEEF, req held high → busy for 4 cycles, then equal=1, cycles=4, not_equal=less=greater=0 held until req drops; all 0 one cycle after req=0.
- x=0x12FFFFFF, y=0x13000000 → mismatch in chunk 0: not_equal=1, less=1, cycles=1 after edge N+1. Change x,y during DONE → outputs unchanged.
- x=0xAABBCC05, y=0xAABBCC04 → greater=1, cycles=4. Swap the operands → less=1.
- SIGNED=1; x=0xFF000000 (negative), y=0x01000000 → less=1, cycles=1. The same operands with SIGNED=0 → greater=1.
- Abort and re-trigger: drop req after 2 CMP cycles → IDLE with no result flag asserted. Holding req high through DONE causes no second compare; a low→high toggle starts a fresh compare.
- Assert rst mid-CMP and separately in DONE → next edge all outputs 0, state IDLE; req held high through reset starts a new capture on the first edge after rst falls.
